// File: rtl/or1k_wb_rr_arbiter.sv
// N-master to 1-slave Wishbone B3 round-robin arbiter; grant is held for the owner's whole cycle.
// Optional bus-timeout watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module or1k_wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0]   m_sel_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]      m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]      m_bte_i,
    output logic [DW-1:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    output logic [NUM_MASTERS-1:0]        m_rty_o,
    output logic [AW-1:0]                 s_adr_o,
    output logic [DW-1:0]                 s_dat_o,
    output logic [DW/8-1:0]               s_sel_o,
    output logic                          s_we_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic [2:0]                    s_cti_o,
    output logic [1:0]                    s_bte_o,
    input  logic [DW-1:0]                 s_dat_i,
    input  logic                          s_ack_i,
    input  logic                          s_err_i,
    input  logic                          s_rty_i,
    output logic [NUM_MASTERS-1:0]        grant_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = DW / 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [IW-1:0]          owner_q;
    logic [IW-1:0]          owner_d;
    logic [IW-1:0]          ptr_q;
    logic [IW-1:0]          ptr_d;

    logic                   granted_s;
    logic [NUM_MASTERS-1:0] owner_oh_s;
    logic                   owner_cyc_s;
    logic                   s_cyc_s;
    logic                   stb_req_s;
    logic                   resp_s;
    logic                   timeout_fire_s;
    logic [IW:0]            pick_s;

    // Round-robin scan starting at ptr; returns {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                            input logic [IW-1:0]          ptr);
        logic          found;
        logic [IW-1:0] pick;
        logic [IW-1:0] idx;
        found = 1'b0;
        pick  = ptr;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx   = IW'((int'(ptr) + i) % NUM_MASTERS);
            pick  = (!found && req[idx]) ? idx : pick;
            found = found | req[idx];
        end
        return {found, pick};
    endfunction

    // Owner-derived helper signals shared by the FSM, watchdog and muxes.
    always_comb begin
        granted_s   = (state_q == ST_GRANT);
        owner_oh_s  = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner_q;
        owner_cyc_s = m_cyc_i[owner_q];
        s_cyc_s     = granted_s & owner_cyc_s;
        stb_req_s   = s_cyc_s & m_stb_i[owner_q];
        resp_s      = s_ack_i | s_err_i | s_rty_i;
        pick_s      = rr_pick(m_cyc_i, ptr_q);
    end

    // Next-state logic: arbitrate in IDLE, hold the owner until it drops cyc.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_s[IW]) begin
                    state_d = ST_GRANT;
                    owner_d = pick_s[IW-1:0];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!owner_cyc_s) begin
                    state_d = ST_IDLE;
                    ptr_d   = (owner_q == IW'(NUM_MASTERS - 1)) ? IW'(0) : owner_q + IW'(1);
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= IW'(0);
            ptr_q   <= IW'(0);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt_q;
    logic [15:0] to_cnt_d;

    // Watchdog: count stalled strobe cycles, fire once at the terminal count.
    always_comb begin
        to_cnt_d       = to_cnt_q;
        timeout_fire_s = 1'b0;
        if (!stb_req_s || resp_s) begin
            to_cnt_d = 16'd0;
        end else if (to_cnt_q == TO_LAST) begin
            to_cnt_d       = 16'd0;
            timeout_fire_s = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + 16'd1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt_q <= 16'd0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    // Without the watchdog, errors only come from the slave.
    always_comb begin
        timeout_fire_s = 1'b0;
    end
`endif

    // Slave-side mux from the owner and response routing back to it.
    always_comb begin
        m_dat_o = s_dat_i;
        grant_o = {NUM_MASTERS{1'b0}};
        s_adr_o = {AW{1'b0}};
        s_dat_o = {DW{1'b0}};
        s_sel_o = {SW{1'b0}};
        s_we_o  = 1'b0;
        s_cti_o = 3'b000;
        s_bte_o = 2'b00;
        s_cyc_o = s_cyc_s;
        s_stb_o = stb_req_s & ~timeout_fire_s;
        m_ack_o = (s_ack_i & s_cyc_s) ? owner_oh_s : {NUM_MASTERS{1'b0}};
        m_rty_o = (s_rty_i & s_cyc_s) ? owner_oh_s : {NUM_MASTERS{1'b0}};
        m_err_o = ((s_err_i & s_cyc_s) | timeout_fire_s) ? owner_oh_s : {NUM_MASTERS{1'b0}};
        if (granted_s) begin
            grant_o = owner_oh_s;
            s_adr_o = m_adr_i[int'(owner_q)*AW +: AW];
            s_dat_o = m_dat_i[int'(owner_q)*DW +: DW];
            s_sel_o = m_sel_i[int'(owner_q)*SW +: SW];
            s_we_o  = m_we_i[owner_q];
            s_cti_o = m_cti_i[int'(owner_q)*3 +: 3];
            s_bte_o = m_bte_i[int'(owner_q)*2 +: 2];
        end else begin
            grant_o = {NUM_MASTERS{1'b0}};
        end
    end

endmodule
